load_store_unit: RTL and testbench

- Executes one data-memory access per request from the core's memory stage.
- Consumes the decoded access size (DataType), address, store data and load sign mode.
- Drives a word-wide data-memory bus with a req/ack handshake, performing byte-lane steering, write-enable generation, load extraction and sign/zero extension.
- Sits between the ALU result (address) and data memory; the core's control FSM stalls on busy.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory access per request, with byte-lane steering,
// load extraction with sign/zero extension, misalignment detection and request timeout.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  is_store_i,
  input  logic [1:0]            data_type_i,
  input  logic                  ld_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StFail} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                  we_q, we_d;
  logic [1:0]            type_q, type_d;
  logic                  uns_q, uns_d;
  logic [1:0]            lane_q, lane_d;
  logic                  misal_q, misal_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;

  assign cnt_inc = cnt_q + CntW'(1);

  // Load extraction from the acknowledged read word.
  assign shifted = mem_rdata_i >> {lane_q, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    load_ext = mem_rdata_i;
    case (type_q)
      2'b01:   load_ext = {{24{~uns_q & byte_v[7]}}, byte_v};
      2'b10:   load_ext = {{16{~uns_q & half_v[15]}}, half_v};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    type_d  = type_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    misal_d = misal_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    if (state_q == StReq) begin
      if (misal_q) begin
        state_d = StFail;
      end else if (mem_ack_i) begin
        state_d = StResp;
        if (!we_q) rdata_d = load_ext;
      end else begin
        cnt_d = cnt_inc;
        if ((TIMEOUT != 0) && (cnt_inc == TimeoutVal)) state_d = StFail;
      end
    end else begin
      // Idle, and the single done cycle of Resp/Fail, both accept a new request.
      state_d = StIdle;
      if (start_i) begin
        state_d = StReq;
        cnt_d   = '0;
        we_d    = is_store_i;
        type_d  = data_type_i;
        uns_d   = ld_unsigned_i;
        lane_d  = addr_i[1:0];
        addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        misal_d = ((data_type_i == 2'b10) && addr_i[0]) ||
                  (((data_type_i == 2'b00) || (data_type_i == 2'b11)) && (addr_i[1:0] != 2'b00));
        case (data_type_i)
          2'b01: begin
            be_d    = 4'b0001 << addr_i[1:0];
            wdata_d = {4{wdata_i[7:0]}};
          end
          2'b10: begin
            be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata_i[15:0]}};
          end
          default: begin
            be_d    = 4'b1111;
            wdata_d = wdata_i;
          end
        endcase
        if (!is_store_i) be_d = 4'b1111;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      type_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      misal_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      type_q  <= type_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      misal_q <= misal_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from state so reset drops the request without a clock edge.
  assign busy_o      = (state_q == StReq);
  assign mem_req_o   = busy_o && !misal_q;
  assign mem_we_o    = mem_req_o && we_q;
  assign done_o      = (state_q == StResp) || (state_q == StFail);
  assign err_o       = (state_q == StFail);
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural access model.
module tb_load_store_unit;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i, is_store_i, ld_unsigned_i, mem_ack_i;
  logic [1:0]    data_type_i;
  logic [AW-1:0] addr_i, mem_addr_o;
  logic [31:0]   wdata_i, rdata_o, mem_wdata_o, mem_rdata_i;
  logic          busy_o, done_o, err_o, mem_req_o, mem_we_o;
  logic [3:0]    mem_be_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .is_store_i   (is_store_i),
    .data_type_i  (data_type_i),
    .ld_unsigned_i(ld_unsigned_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic misaligned(input logic [1:0] dt, input logic [31:0] a);
    if (dt == 2'd1) return 1'b0;
    if (dt == 2'd2) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] dt, input logic uns,
                                             input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    if (dt == 2'd1) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (dt == 2'd2) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_be(input logic st, input logic [1:0] dt,
                                           input logic [31:0] a);
    if (!st) return 32'hF;
    if (dt == 2'd1) return 32'h1 << (a % 4);
    if (dt == 2'd2) return ((a % 4) >= 2) ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] dt, input logic [31:0] w);
    if (dt == 2'd1) return (w & 32'hFF) * 32'h0101_0101;
    if (dt == 2'd2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  // ack_at: cycle (>=1) in which ack is driven, 0 = never. junk: stray ack alongside start
  // plus a start pulse with scrambled inputs while busy.
  task automatic run_txn(input logic st, input logic [1:0] dt, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                         input int ack_at, input logic junk);
    logic mis;
    logic acked;
    int   cyc;
    mis   = misaligned(dt, a);
    acked = 1'b0;
    @(negedge clk_i);
    check_eq("idle_done", 32'(done_o), 32'h0);
    check_eq("idle_busy", 32'(busy_o), 32'h0);
    start_i = 1'b1; is_store_i = st; data_type_i = dt; ld_unsigned_i = uns;
    addr_i = a; wdata_i = wd; mem_rdata_i = rw; mem_ack_i = junk;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    start_i   = junk;
    if (junk) begin
      is_store_i = ~st; data_type_i = 2'($urandom); addr_i = $urandom; wdata_i = $urandom;
    end
    if (mis) begin
      check_eq("mis_busy", 32'(busy_o), 32'h1);
      check_eq("mis_req", 32'(mem_req_o), 32'h0);
      check_eq("mis_done1", 32'(done_o), 32'h0);
      @(negedge clk_i);
      start_i = 1'b0;
      check_eq("mis_done", 32'(done_o), 32'h1);
      check_eq("mis_err", 32'(err_o), 32'h1);
      check_eq("mis_busy2", 32'(busy_o), 32'h0);
      check_eq("mis_req2", 32'(mem_req_o), 32'h0);
      check_eq("mis_rdata", rdata_o, exp_rdata);
      return;
    end
    cyc = 1;
    forever begin
      check_eq("req", 32'(mem_req_o), 32'h1);
      check_eq("req_busy", 32'(busy_o), 32'h1);
      check_eq("req_done", 32'(done_o), 32'h0);
      if (cyc == 1) begin
        check_eq("mem_addr", mem_addr_o, a & 32'hFFFF_FFFC);
        check_eq("mem_be", 32'(mem_be_o), model_be(st, dt, a));
        check_eq("mem_we", 32'(mem_we_o), 32'(st));
        if (st) check_eq("mem_wdata", mem_wdata_o, model_wdata(dt, wd));
      end
      mem_ack_i = (cyc == ack_at);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      start_i   = 1'b0;
      if (cyc == ack_at) begin
        acked = 1'b1;
        break;
      end
      if (cyc == TMO) break;
      cyc++;
      if (cyc > 300) begin
        check_eq("req_bound", 32'(cyc), 32'h0);
        break;
      end
    end
    if (acked && !st) exp_rdata = model_load(dt, uns, a, rw);
    check_eq("end_done", 32'(done_o), 32'h1);
    check_eq("end_err", 32'(err_o), 32'(!acked));
    check_eq("end_busy", 32'(busy_o), 32'h0);
    check_eq("end_req", 32'(mem_req_o), 32'h0);
    check_eq("end_rdata", rdata_o, exp_rdata);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; is_store_i = 1'b0; data_type_i = 2'd0; ld_unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
    check_eq("rst_done", 32'(done_o), 32'h0);
    check_eq("rst_err", 32'(err_o), 32'h0);
    check_eq("rst_req", 32'(mem_req_o), 32'h0);
    check_eq("rst_we", 32'(mem_we_o), 32'h0);
    check_eq("rst_rdata", rdata_o, 32'h0);
    check_eq("rst_addr", mem_addr_o, 32'h0);
    check_eq("rst_be", 32'(mem_be_o), 32'h0);
    check_eq("rst_wdata", mem_wdata_o, 32'h0);
    rst_ni = 1'b1;

    // Directed cases.
    run_txn(1'b1, 2'd1, 1'b0, 32'h1003, 32'h0000_00A5, 32'h0, 2, 1'b0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 1, 1'b0);
    run_txn(1'b0, 2'd2, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 1, 1'b0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h3001, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h4000, 32'h0, 32'h1111_2222, 0, 1'b1);
    run_txn(1'b0, 2'd0, 1'b0, 32'h5000, 32'h0, 32'hAAAA_5555, 1, 1'b0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h5004, 32'h0, 32'h1357_9BDF, 1, 1'b0);

    // Reset while a request is outstanding.
    @(negedge clk_i);
    start_i = 1'b1; is_store_i = 1'b0; data_type_i = 2'd0; addr_i = 32'h6000;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    check_eq("pre_rst_req", 32'(mem_req_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("async_req", 32'(mem_req_o), 32'h0);
    check_eq("async_busy", 32'(busy_o), 32'h0);
    check_eq("async_done", 32'(done_o), 32'h0);
    exp_rdata = 32'h0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_txn(1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 32'h0000_007F, 1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] dt;
      int ack;
      dt  = 2'($urandom);
      ack = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
      run_txn(1'($urandom), dt, 1'($urandom), $urandom, $urandom, $urandom, ack,
              1'($urandom));
    end

    @(negedge clk_i);
    check_eq("final_done", 32'(done_o), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
